reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 8-entry x 16-bit general-purpose register file for the single-cycle CPU.
- Sits directly downstream of the write-back select mux: its write-data input is the 4:1 mux output (ALU result / memory data / PC+1 / immediate).
- Its read ports feed the ALU operand muxes.
- Two asynchronous read ports, one synchronous write port, register 0 hardwired to zero.

Parameters:
- DATA_W, 16, register and port data width.
- NREGS, 8, number of architectural registers (power of two).
- ADDR_W, 3, register index width, equal to log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- we  input  1  write enable for the current cycle.
- wa  input  ADDR_W  write register index.
- wd  input  DATA_W  write data from the write-back select mux.
- ra1  input  ADDR_W  read port 1 index (rs).
- ra2  input  ADDR_W  read port 2 index (rt).
- rd1  output  DATA_W  read port 1 data.
- rd2  output  DATA_W  read port 2 data.
- wr_cnt  output  16  count of committed writes, for debug and verification.

Behaviour:
- Interface (already decided): single clock clk; rst is asynchronous and active-high.
- Storage: NREGS registers of DATA_W bits, r0..r(NREGS-1).
- Reset:
  - rst high immediately clears every register to 0 and wr_cnt to 0, with no clock edge needed.
  - While rst is high, rd1 = rd2 = 0 and writes are ignored.
  - Deassertion takes effect at the next rising clk edge.
- Write:
  - At rising clk with rst low, we = 1 and wa != 0: reg[wa] <= wd and wr_cnt <= wr_cnt + 1.
  - wr_cnt wraps modulo 2^16 (0xFFFF + 1 = 0x0000).
  - we = 1 with wa = 0: no state change and wr_cnt is not incremented.
  - we = 0: no state change.
- Read:
  - Combinational, zero latency: rdN = reg[raN].
  - raN = 0 always returns 0, regardless of any write attempted to r0.
  - Both ports may read the same index at the same time; each returns the same value.
- Same-cycle read/write to the same index (raN == wa, we = 1, wa != 0): behaviour depends on the optional feature (see below).
- Reset mid-write: if rst rises in the same cycle as a write, the write is lost and the register reads 0 afterwards.
- No handshake: the CPU is single-cycle, so one write per cycle, accepted unconditionally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass. When rst = 0, we = 1, wa != 0 and raN == wa, rdN = wd combinationally in the same cycle.
  - r0 reads still return 0.
- Undefined:
  - rdN returns the old stored value until after the rising edge.
  - The new value is visible in the cycle following the write.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W = 16, REG_ADDR_W = 3, NREGS = 8.
  - typedef word_t (logic [DATA_W-1:0]) and reg_idx_t (logic [REG_ADDR_W-1:0]).
  - Constant ZERO_REG = 0.
  - This package is shared with the ALU, the muxes and the decoder.
- One natural sub-module: reg_word.
  - A single DATA_W flop with async active-high clear and write enable, instantiated NREGS-1 times in a generate loop.
  - r0 is a constant 0, not a flop.
- Read selection, the bypass compare and wr_cnt stay in reg_file.

Test Plan:
- Reset: assert rst mid-simulation after writing r3 = 0x1234 -> rd1 (ra1 = 3) reads 0x0000 immediately with no clock edge; wr_cnt = 0.
- Basic write/read: write r5 = 0xBEEF, then ra1 = 5, ra2 = 5 -> both read 0xBEEF; wr_cnt = 1.
- r0 protection: we = 1, wa = 0, wd = 0xFFFF -> rd1 (ra1 = 0) = 0x0000; wr_cnt unchanged.
- Same-cycle read/write: r2 holds 0x0001, write wa = 2, wd = 0x00AA, ra1 = 2.
  - With REGFILE_BYPASS_EN: rd1 = 0x00AA before the edge.
  - Without REGFILE_BYPASS_EN: rd1 = 0x0001 before the edge and 0x00AA after it.
- Full sweep: write r1..r7 with 0x1111 * i, read all pairs via ra1/ra2 -> exact values returned; r0 = 0; wr_cnt = 7.
- Counter wrap: preload via 65535 writes to r1, then one more write -> wr_cnt = 0x0000; r1 holds the last wd.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants.
// Used by the register file, ALU, muxes and decoder.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREGS      = 8;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_word.sv
// One register-file word: DATA_W flop with
// async active-high clear and write enable.
module reg_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // hold value unless enabled; clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_file.sv
// 8x16 register file: 2 async reads, 1 sync write, r0 = 0.
// Build option: REGFILE_BYPASS_EN adds write-through read bypass.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS  = cpu_pkg::NREGS,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       wr_cnt
);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         wr_ok;

  assign wr_ok   = we && (wa != ADDR_W'(ZERO_REG));
  assign regs[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_word
    reg_word #(.W(DATA_W)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_ok && (wa == ADDR_W'(i))),
      .d   (wd),
      .q   (regs[i])
    );
  end

  // count committed (non-r0) writes, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wr_cnt <= '0;
    else if (wr_ok) wr_cnt <= wr_cnt + 16'd1;
  end

  // read port 1: stored value, optionally bypassed from wd
  always_comb begin
    rd1 = regs[ra1];
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_ok && (ra1 == wa)) rd1 = wd;
`endif
  end

  // read port 2: stored value, optionally bypassed from wd
  always_comb begin
    rd2 = regs[ra2];
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_ok && (ra2 == wa)) rd2 = wd;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array model.
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  wa, ra1, ra2;
  logic [15:0] wd, rd1, rd2, wr_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];
  logic [15:0] cnt;

  always #5 clk = ~clk;

  reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .wr_cnt (wr_cnt)
  );

  function automatic logic [15:0] exp_rd(input logic [2:0] ra);
    if (ra == 3'd0) return 16'h0000;
    if (rst) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 3'd0 && ra == wa) return wd;
`endif
    return model[ra];
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    cnt = 16'h0000;
  endtask

  // one rising edge; the model commits what the spec says commits
  task automatic tick;
    @(posedge clk);
    if (rst) clear_model();
    else if (we && wa != 3'd0) begin
      model[wa] = wd;
      cnt = cnt + 16'd1;
    end
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    we  = 1'b0;
    clear_model();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    ra1 = 3'd3; ra2 = 3'd7;
    #1;
    checks++;
    if (rd1 !== 16'h0 || rd2 !== 16'h0 || wr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_state rd1=%h rd2=%h cnt=%h want 0", rd1, rd2, wr_cnt);
    end
    we = 1'b1; wa = 3'd3; wd = 16'h1234;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 16'h1234) begin
      errors++;
      $display("FAIL pre_reset_r3 got %h want 1234", rd1);
    end
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    checks++;
    if (rd1 !== 16'h0 || wr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_clear rd1=%h cnt=%h want 0", rd1, wr_cnt);
    end
    we = 1'b1; wa = 3'd3; wd = 16'h5555; ra2 = 3'd3;
    #1;
    checks++;
    if (rd2 !== 16'h0) begin
      errors++;
      $display("FAIL rst_read_bypass got %h want 0", rd2);
    end
    tick();
    checks++;
    if (rd1 !== 16'h0 || wr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL write_in_rst rd1=%h cnt=%h want 0", rd1, wr_cnt);
    end
    rst = 1'b0;
    we = 1'b1; wa = 3'd4; wd = 16'h7777; ra1 = 3'd4;
    #2;
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    we  = 1'b0;
    #1;
    checks++;
    if (rd1 !== 16'h0 || wr_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_write rd1=%h cnt=%h want 0", rd1, wr_cnt);
    end
  endtask

  task automatic test_basic;
    apply_reset();
    we = 1'b1; wa = 3'd5; wd = 16'hBEEF;
    tick();
    we = 1'b0; ra1 = 3'd5; ra2 = 3'd5;
    #1;
    checks++;
    if (rd1 !== 16'hBEEF || rd2 !== 16'hBEEF) begin
      errors++;
      $display("FAIL basic_rw rd1=%h rd2=%h want beef", rd1, rd2);
    end
    checks++;
    if (wr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_cnt got %h want 1", wr_cnt);
    end
  endtask

  task automatic test_r0;
    we = 1'b1; wa = 3'd0; wd = 16'hFFFF; ra1 = 3'd0;
    #1;
    checks++;
    if (rd1 !== 16'h0) begin
      errors++;
      $display("FAIL r0_pre got %h want 0", rd1);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 16'h0 || wr_cnt !== cnt) begin
      errors++;
      $display("FAIL r0_protect rd1=%h cnt=%h want 0 / %h", rd1, wr_cnt, cnt);
    end
  endtask

  task automatic test_same_cycle;
    logic [15:0] want;
    we = 1'b1; wa = 3'd2; wd = 16'h0001;
    tick();
    wd = 16'h00AA; ra1 = 3'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 16'h00AA;
`else
    want = 16'h0001;
`endif
    checks++;
    if (rd1 !== want) begin
      errors++;
      $display("FAIL same_cycle_pre got %h want %h", rd1, want);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 16'h00AA) begin
      errors++;
      $display("FAIL same_cycle_post got %h want 00aa", rd1);
    end
  endtask

  task automatic test_sweep;
    apply_reset();
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 16'(16'h1111 * i);
      tick();
    end
    we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        ra1 = 3'(a); ra2 = 3'(b);
        #1;
        checks++;
        if (rd1 !== 16'(16'h1111 * a) || rd2 !== 16'(16'h1111 * b)) begin
          errors++;
          $display("FAIL sweep ra1=%0d ra2=%0d got %h %h want %h %h",
                   a, b, rd1, rd2, 16'(16'h1111 * a), 16'(16'h1111 * b));
        end
      end
    end
    checks++;
    if (wr_cnt !== 16'd7) begin
      errors++;
      $display("FAIL sweep_cnt got %h want 7", wr_cnt);
    end
  endtask

  task automatic test_random;
    logic [15:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      #1;
      e1 = exp_rd(ra1);
      e2 = exp_rd(ra2);
      checks++;
      if (rd1 !== e1 || rd2 !== e2) begin
        errors++;
        $display("FAIL random n=%0d ra=%0d/%0d got %h %h want %h %h",
                 n, ra1, ra2, rd1, rd2, e1, e2);
      end
      tick();
    end
    we = 1'b0;
    #1;
    checks++;
    if (wr_cnt !== cnt) begin
      errors++;
      $display("FAIL random_cnt got %h want %h", wr_cnt, cnt);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    we = 1'b1; wa = 3'd1;
    for (int i = 0; i < 65535; i++) begin
      wd = 16'(i);
      tick();
    end
    checks++;
    if (wr_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre got %h want ffff", wr_cnt);
    end
    wd = 16'hC0DE;
    tick();
    we = 1'b0; ra1 = 3'd1;
    #1;
    checks++;
    if (wr_cnt !== 16'h0000 || rd1 !== 16'hC0DE) begin
      errors++;
      $display("FAIL wrap cnt=%h r1=%h want 0000 c0de", wr_cnt, rd1);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    clear_model();
    test_reset();
    test_basic();
    test_r0();
    test_same_cycle();
    test_sweep();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
